ecc_mem_ctrl: RTL and testbench

ECC memory controller that sequences the shared `edcg_mod` SEC-DED encoder/checker between CPU reads, CPU writes, correction write-backs and a background scrubber. It sits between a single-requester memory port and a single-port synchronous SRAM holding 32 data bits plus 8 check bits per word. It detects and corrects single-bit errors, flags double-bit errors, and maintains error counters.

---
 rtl/ecc_pkg.sv | 62 ++++++
 rtl/edcg_mod.sv | 26 ++
 rtl/ecc_mem_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_ecc_mem_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// rtl/ecc_pkg.sv - shared types, H-matrix columns and syndrome decode table for the ECC controller
package ecc_pkg;

    localparam int DATA_W = 32;
    localparam int ECC_W  = 8;
    localparam int CNT_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_CHK,
        ST_FIX,
        ST_WB
    } state_e;

    typedef enum logic [1:0] {
        POS_NONE,
        POS_DATA,
        POS_CHK,
        POS_PAR
    } pos_kind_e;

    typedef struct packed {
        pos_kind_e  kind;
        logic [5:0] idx;
    } pos_t;

    // Data bit i sits at the i-th non-power-of-two Hamming position (3, 5, 6, 7, 9, ...).
    function automatic logic [DATA_W*7-1:0] gen_data_cols();
        logic [DATA_W*7-1:0] cols;
        int n;
        cols = '0;
        n = 0;
        for (int p = 3; p < 64; p++) begin
            if (((p & (p - 1)) != 0) && (n < DATA_W)) begin
                cols[n*7 +: 7] = 7'(p);
                n = n + 1;
            end
        end
        return cols;
    endfunction

    localparam logic [DATA_W*7-1:0] DATA_COLS = gen_data_cols();

    // Indexed by S[6:0] when S[7]=1; zero syndrome bits mean the overall parity bit flipped.
    function automatic logic [128*8-1:0] gen_syn2pos();
        logic [128*8-1:0] t;
        t = '0;
        t[0 +: 8] = {POS_PAR, 6'd0};
        for (int j = 0; j < 7; j++) begin
            t[(1 << j) * 8 +: 8] = {POS_CHK, 6'(j)};
        end
        for (int i = 0; i < DATA_W; i++) begin
            t[32'(DATA_COLS[i*7 +: 7]) * 8 +: 8] = {POS_DATA, 6'(i)};
        end
        return t;
    endfunction

    localparam logic [128*8-1:0] SYN2POS = gen_syn2pos();

endpackage

// File: rtl/edcg_mod.sv
// rtl/edcg_mod.sv - SEC-DED encoder (R=0) / syndrome generator (R=1), extended Hamming over 32 data bits
module edcg_mod
    import ecc_pkg::*;
(
    input  logic        R,
    input  logic [31:0] ID,
    input  logic [7:0]  IC,
    output logic [7:0]  S
);

    logic [6:0] chk;

    always_comb begin
        chk = '0;
        for (int i = 0; i < DATA_W; i++) begin
            chk = chk ^ (DATA_COLS[i*7 +: 7] & {7{ID[i]}});
        end
        // The overall parity term folds in the stored check bits so check-bit flips read as single errors.
        if (R) begin
            S = {IC[7] ^ (^ID) ^ (^IC[6:0]), IC[6:0] ^ chk};
        end else begin
            S = {(^ID) ^ (^chk), chk};
        end
    end

endmodule

// File: rtl/ecc_mem_ctrl.sv
// rtl/ecc_mem_ctrl.sv - SEC-DED SRAM controller with correction write-back, scrubber and error counters
module ecc_mem_ctrl
    import ecc_pkg::*;
#(
    parameter int ADDR_W         = 10,
    parameter int SCRUB_INTERVAL = 1024,
    parameter bit SCRUB_EN       = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic              o_ack,
    output logic [31:0]       o_rdata,
    output logic              o_err,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    output logic [7:0]        o_mem_wecc,
    input  logic [31:0]       i_mem_rdata,
    input  logic [7:0]        i_mem_recc,
    output logic              o_sbe,
    output logic              o_dbe,
    output logic [15:0]       o_sbe_cnt,
    output logic [15:0]       o_dbe_cnt,
    output logic [ADDR_W-1:0] o_err_addr
);

    localparam int SCW = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;
    localparam logic [SCW-1:0] SCRUB_MAX = SCW'(SCRUB_INTERVAL - 1);

    state_e            state, state_d;
    logic [SCW-1:0]    scrub_cnt, scrub_cnt_d;
    logic [ADDR_W-1:0] scrub_addr, scrub_addr_d;
    logic [ADDR_W-1:0] cur_addr, cur_addr_d;
    logic              is_scrub, is_scrub_d;
    logic [31:0]       fix_data, fix_data_d;

    logic              ack_d, err_d, sbe_d, dbe_d, mem_en_d, mem_we_d;
    logic [31:0]       rdata_d, mem_wdata_d;
    logic [7:0]        mem_wecc_d;
    logic [ADDR_W-1:0] mem_addr_d, err_addr_d;
    logic [CNT_W-1:0]  sbe_cnt_d, dbe_cnt_d;

    logic              edc_r;
    logic [31:0]       edc_id;
    logic [7:0]        edc_s;
    logic              sbe_hit, dbe_hit, scrub_due;
    pos_t              pos;
    logic [31:0]       flip, corrected;

    always_comb begin
        edc_r  = 1'b0;
        edc_id = i_wdata;
        case (state)
            ST_CHK: begin
                edc_r  = 1'b1;
                edc_id = i_mem_rdata;
            end
            ST_FIX:  edc_id = fix_data;
            default: ;
        endcase
    end

    edcg_mod u_edcg (
        .R  (edc_r),
        .ID (edc_id),
        .IC (i_mem_recc),
        .S  (edc_s)
    );

    assign sbe_hit   = edc_s[7];
    assign dbe_hit   = !edc_s[7] && (edc_s[6:0] != 7'd0);
    assign pos       = pos_t'(SYN2POS[{edc_s[6:0], 3'b000} +: 8]);
    assign flip      = (sbe_hit && pos.kind == POS_DATA) ? (32'd1 << pos.idx) : 32'd0;
    assign corrected = i_mem_rdata ^ flip;
    assign scrub_due = SCRUB_EN && (scrub_cnt == SCRUB_MAX);

    always_comb begin
        state_d      = state;
        scrub_cnt_d  = scrub_cnt;
        scrub_addr_d = scrub_addr;
        cur_addr_d   = cur_addr;
        is_scrub_d   = is_scrub;
        fix_data_d   = fix_data;
        ack_d        = 1'b0;
        err_d        = 1'b0;
        sbe_d        = 1'b0;
        dbe_d        = 1'b0;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        rdata_d      = o_rdata;
        mem_addr_d   = o_mem_addr;
        mem_wdata_d  = o_mem_wdata;
        mem_wecc_d   = o_mem_wecc;
        err_addr_d   = o_err_addr;
        sbe_cnt_d    = o_sbe_cnt;
        dbe_cnt_d    = o_dbe_cnt;

        case (state)
            ST_IDLE: begin
                if (scrub_cnt != SCRUB_MAX) begin
                    scrub_cnt_d = scrub_cnt + 1'b1;
                end
                // The CPU wins over a due scrub; a request seen during its own ack cycle is stale.
                if (i_req && !o_ack) begin
                    cur_addr_d = i_addr;
                    is_scrub_d = 1'b0;
                    mem_en_d   = 1'b1;
                    mem_addr_d = i_addr;
                    if (i_we) begin
                        mem_we_d    = 1'b1;
                        mem_wdata_d = i_wdata;
                        mem_wecc_d  = edc_s;
                        state_d     = ST_WR;
                    end else begin
                        state_d = ST_RD;
                    end
                end else if (scrub_due) begin
                    scrub_cnt_d = '0;
                    cur_addr_d  = scrub_addr;
                    is_scrub_d  = 1'b1;
                    mem_en_d    = 1'b1;
                    mem_addr_d  = scrub_addr;
                    state_d     = ST_RD;
                end
            end
            ST_WR: begin
                ack_d   = 1'b1;
                state_d = ST_IDLE;
            end
            ST_RD: state_d = ST_CHK;
            ST_CHK: begin
                fix_data_d = corrected;
                if (is_scrub) begin
                    scrub_addr_d = scrub_addr + 1'b1;
                end else begin
                    ack_d   = 1'b1;
                    rdata_d = corrected;
                    err_d   = dbe_hit;
                end
                if (sbe_hit) begin
                    sbe_d      = 1'b1;
                    err_addr_d = cur_addr;
                    if (o_sbe_cnt != {CNT_W{1'b1}}) sbe_cnt_d = o_sbe_cnt + 1'b1;
                    state_d    = ST_FIX;
                end else if (dbe_hit) begin
                    dbe_d      = 1'b1;
                    err_addr_d = cur_addr;
                    if (o_dbe_cnt != {CNT_W{1'b1}}) dbe_cnt_d = o_dbe_cnt + 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FIX: begin
                mem_en_d    = 1'b1;
                mem_we_d    = 1'b1;
                mem_addr_d  = cur_addr;
                mem_wdata_d = fix_data;
                mem_wecc_d  = edc_s;
                state_d     = ST_WB;
            end
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            scrub_cnt   <= '0;
            scrub_addr  <= '0;
            cur_addr    <= '0;
            is_scrub    <= 1'b0;
            fix_data    <= '0;
            o_ack       <= 1'b0;
            o_rdata     <= '0;
            o_err       <= 1'b0;
            o_mem_en    <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_mem_wecc  <= '0;
            o_sbe       <= 1'b0;
            o_dbe       <= 1'b0;
            o_sbe_cnt   <= '0;
            o_dbe_cnt   <= '0;
            o_err_addr  <= '0;
        end else begin
            scrub_cnt   <= scrub_cnt_d;
            scrub_addr  <= scrub_addr_d;
            cur_addr    <= cur_addr_d;
            is_scrub    <= is_scrub_d;
            fix_data    <= fix_data_d;
            o_ack       <= ack_d;
            o_rdata     <= rdata_d;
            o_err       <= err_d;
            o_mem_en    <= mem_en_d;
            o_mem_we    <= mem_we_d;
            o_mem_addr  <= mem_addr_d;
            o_mem_wdata <= mem_wdata_d;
            o_mem_wecc  <= mem_wecc_d;
            o_sbe       <= sbe_d;
            o_dbe       <= dbe_d;
            o_sbe_cnt   <= sbe_cnt_d;
            o_dbe_cnt   <= dbe_cnt_d;
            o_err_addr  <= err_addr_d;
        end
    end

endmodule

// File: tb/tb_ecc_mem_ctrl.sv
// tb/tb_ecc_mem_ctrl.sv - directed self-checking bench for ecc_mem_ctrl with a behavioural SRAM
module tb_ecc_mem_ctrl;

    localparam logic [31:0] D_GOOD = 32'hE3A02001;
    localparam logic [31:0] D_SBE  = 32'hE3A02000;
    localparam logic [31:0] D_DBE  = 32'hE3A02002;
    localparam logic [7:0]  E_GOOD = 8'hB0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [9:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic        ack, err, mem_en, mem_we, sbe, dbe;
    logic [31:0] rdata, mem_wdata;
    logic [7:0]  mem_wecc;
    logic [9:0]  mem_addr, err_addr;
    logic [15:0] sbe_cnt, dbe_cnt;
    logic [39:0] rd_q = '0;

    logic [39:0] mem [1024] = '{default: '0};
    logic        bd_we = 1'b0;
    logic [9:0]  bd_addr = '0;
    logic [39:0] bd_data = '0;

    int wr_cnt = 0;
    logic [9:0]  wr_addr = '0;
    logic [39:0] wr_word = '0;
    int ack_cnt = 0;
    int sbe_seen = 0;
    int dbe_seen = 0;

    int n_checks = 0;
    int n_errs = 0;

    always #5 clk = ~clk;

    ecc_mem_ctrl #(
        .ADDR_W         (10),
        .SCRUB_INTERVAL (8),
        .SCRUB_EN       (1'b1)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req       (req),
        .i_we        (we),
        .i_addr      (addr),
        .i_wdata     (wdata),
        .o_ack       (ack),
        .o_rdata     (rdata),
        .o_err       (err),
        .o_mem_en    (mem_en),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .o_mem_wecc  (mem_wecc),
        .i_mem_rdata (rd_q[31:0]),
        .i_mem_recc  (rd_q[39:32]),
        .o_sbe       (sbe),
        .o_dbe       (dbe),
        .o_sbe_cnt   (sbe_cnt),
        .o_dbe_cnt   (dbe_cnt),
        .o_err_addr  (err_addr)
    );

    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        if (mem_en) begin
            if (mem_we) begin
                mem[mem_addr] <= {mem_wecc, mem_wdata};
                wr_cnt  <= wr_cnt + 1;
                wr_addr <= mem_addr;
                wr_word <= {mem_wecc, mem_wdata};
            end else begin
                rd_q <= mem[mem_addr];
            end
        end
    end

    always @(negedge clk) begin
        if (ack) ack_cnt <= ack_cnt + 1;
        if (sbe) sbe_seen <= sbe_seen + 1;
        if (dbe) dbe_seen <= dbe_seen + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset(input logic bd, input logic [9:0] a, input logic [39:0] d);
        rst_n   = 1'b0;
        req     = 1'b0;
        bd_we   = bd;
        bd_addr = a;
        bd_data = d;
        @(posedge clk);
        #1;
        bd_we = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic do_req(input logic w, input logic [9:0] a, input logic [31:0] d, output int lat);
        req   = 1'b1;
        we    = w;
        addr  = a;
        wdata = d;
        lat   = 0;
        while (lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (ack) break;
        end
        req = 1'b0;
    endtask

    int lat, w0, a0, s0, d0, n;
    logic found;

    initial begin
        do_reset(1'b0, '0, '0);
        check("rst_ctl", {ack, err, sbe, dbe, mem_en, mem_we}, 0);
        check("rst_data", {rdata, mem_wdata}, 0);
        check("rst_cnt", {sbe_cnt, dbe_cnt}, 0);
        check("rst_addr", {mem_addr, err_addr, mem_wecc}, 0);

        w0 = wr_cnt;
        do_req(1'b1, 10'h005, D_GOOD, lat);
        check("wr_lat", lat, 2);
        check("wr_cnt", wr_cnt - w0, 1);
        check("wr_addr", wr_addr, 10'h005);
        check("wr_word", wr_word, {E_GOOD, D_GOOD});
        @(posedge clk);
        #1;
        check("wr_ack_width", ack, 0);

        w0 = wr_cnt; s0 = sbe_seen; d0 = dbe_seen;
        do_req(1'b0, 10'h005, '0, lat);
        check("rd_lat", lat, 3);
        check("rd_data", rdata, D_GOOD);
        check("rd_err", err, 0);
        repeat (3) @(posedge clk);
        #1;
        check("rd_sbe", sbe_seen - s0, 0);
        check("rd_dbe", dbe_seen - d0, 0);
        check("rd_nowrite", wr_cnt - w0, 0);

        do_reset(1'b1, 10'h005, {E_GOOD, D_SBE});
        w0 = wr_cnt;
        do_req(1'b0, 10'h005, '0, lat);
        check("sbe_lat", lat, 3);
        check("sbe_data", rdata, D_GOOD);
        check("sbe_err", err, 0);
        check("sbe_pulse", sbe, 1);
        check("sbe_cnt", sbe_cnt, 1);
        check("sbe_err_addr", err_addr, 10'h005);
        repeat (2) @(posedge clk);
        #1;
        check("sbe_wb_cnt", wr_cnt - w0, 1);
        check("sbe_wb_word", mem[5], {E_GOOD, D_GOOD});

        do_reset(1'b1, 10'h005, {E_GOOD, D_DBE});
        w0 = wr_cnt; d0 = dbe_seen;
        do_req(1'b0, 10'h005, '0, lat);
        check("dbe_lat", lat, 3);
        check("dbe_err", err, 1);
        check("dbe_pulse", dbe, 1);
        check("dbe_cnts", {sbe_cnt, dbe_cnt}, {16'd0, 16'd1});
        check("dbe_err_addr", err_addr, 10'h005);
        repeat (3) @(posedge clk);
        #1;
        check("dbe_nowrite", wr_cnt - w0, 0);
        check("dbe_pulses", dbe_seen - d0, 1);

        do_reset(1'b1, 10'h005, {E_GOOD, D_GOOD});
        repeat (7) @(posedge clk);
        #1;
        req = 1'b1; we = 1'b0; addr = 10'h005;
        @(posedge clk);
        #1;
        check("prio_en", {mem_en, mem_we}, 2'b10);
        check("prio_addr", mem_addr, 10'h005);
        lat = 0;
        while (lat < 10 && !ack) begin
            @(posedge clk);
            #1;
            lat++;
        end
        req = 1'b0;
        check("prio_lat", lat, 2);
        check("prio_data", rdata, D_GOOD);
        found = 1'b0; n = 0;
        while (n < 10 && !found) begin
            @(posedge clk);
            #1;
            n++;
            if (mem_en && !mem_we && mem_addr == 10'h000) found = 1'b1;
        end
        check("prio_scrub_after", found, 1);

        do_reset(1'b1, 10'h000, {E_GOOD, D_SBE});
        a0 = ack_cnt; w0 = wr_cnt;
        found = 1'b0; n = 0;
        while (n < 30 && !found) begin
            @(posedge clk);
            #1;
            n++;
            if (mem_en && !mem_we) found = 1'b1;
        end
        check("scrub0_cycle", n, 8);
        check("scrub0_addr", mem_addr, 10'h000);
        repeat (4) @(posedge clk);
        #1;
        check("scrub0_wb", mem[0], {E_GOOD, D_GOOD});
        check("scrub0_wb_cnt", wr_cnt - w0, 1);
        check("scrub0_sbe_cnt", sbe_cnt, 1);
        check("scrub0_err_addr", err_addr, 10'h000);
        found = 1'b0; n = 0;
        while (n < 30 && !found) begin
            @(posedge clk);
            #1;
            n++;
            if (mem_en && !mem_we) found = 1'b1;
        end
        check("scrub1_cycle", n, 8);
        check("scrub1_addr", mem_addr, 10'h001);
        repeat (3) @(posedge clk);
        #1;
        check("scrub_no_ack", ack_cnt - a0, 0);

        do_reset(1'b1, 10'h005, {E_GOOD, D_SBE});
        a0 = ack_cnt; w0 = wr_cnt;
        req = 1'b1; we = 1'b0; addr = 10'h005;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        req = 1'b0;
        @(posedge clk);
        #1;
        check("rstchk_ctl", {ack, err, sbe, dbe, mem_en, mem_we}, 0);
        check("rstchk_data", {rdata, mem_wdata}, 0);
        check("rstchk_cnt", {sbe_cnt, dbe_cnt}, 0);
        check("rstchk_addr", {mem_addr, err_addr, mem_wecc}, 0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("rstchk_no_ack", ack_cnt - a0, 0);
        check("rstchk_no_wb", wr_cnt - w0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
